// File: rtl/rv64_pkg.sv
// Shared rv64 definitions: datapath width, load funct3 encodings and the
// writeback request record used by the writeback unit and its FIFO.
package rv64_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LD  = 3'b011;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_LWU = 3'b110;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rv64_wb_fifo.sv
// Synchronous FIFO of pending ALU writebacks. Pointers carry a wrap bit so
// full and empty are distinguished without a counter; push and pop may
// coincide, including when full.
module rv64_wb_fifo
   import rv64_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push is about to use.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_req;
   end

endmodule

// File: rtl/rv64_wb_unit.sv
// Integer register-file writeback: extends load data, arbitrates loads over
// buffered/bypassed ALU results, registers one write per cycle.
// Optional decode forwarding of the in-flight write under `WB_FWD_EN.
module rv64_wb_unit
   import rv64_pkg::*;
#(
   parameter int XLEN           = rv64_pkg::XLEN,
   parameter int ALU_FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [XLEN-1:0] ld_data,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
`ifdef WB_FWD_EN
   input  logic [4:0]      fwd_rs1_index,
   input  logic [4:0]      fwd_rs2_index,
   output logic            fwd_rs1_hit,
   output logic            fwd_rs2_hit,
   output logic [XLEN-1:0] fwd_rs1_data,
   output logic [XLEN-1:0] fwd_rs2_data,
`endif
   output logic            alu_pending
);

   logic            ld_keep;
   logic            alu_keep;
   logic [XLEN-1:0] ld_ext;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   wb_req_t         fifo_head;
   wb_req_t         alu_req;
   logic            wr_en;
   wb_req_t         wr_req;

   assign ld_ready  = 1'b1;
   // Results for x0 complete their handshake but are dropped here.
   assign ld_keep   = ld_valid && (ld_rd != 5'd0);
   assign fifo_pop  = !ld_keep && !fifo_empty;
   assign alu_ready = !rst && (!fifo_full || fifo_pop);
   assign alu_keep  = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign alu_req   = '{rd: alu_rd, data: alu_data};
   assign fifo_push = alu_keep && (ld_keep || !fifo_empty);
   assign alu_pending = !fifo_empty;

   always_comb begin
      ld_ext = ld_data;
      unique case (ld_funct3)
         FUNCT3_LB:  ld_ext = {{(XLEN-8){ld_data[7]}},   ld_data[7:0]};
         FUNCT3_LH:  ld_ext = {{(XLEN-16){ld_data[15]}}, ld_data[15:0]};
         FUNCT3_LW:  ld_ext = {{(XLEN-32){ld_data[31]}}, ld_data[31:0]};
         FUNCT3_LBU: ld_ext = {{(XLEN-8){1'b0}},  ld_data[7:0]};
         FUNCT3_LHU: ld_ext = {{(XLEN-16){1'b0}}, ld_data[15:0]};
         FUNCT3_LWU: ld_ext = {{(XLEN-32){1'b0}}, ld_data[31:0]};
         default:    ld_ext = ld_data;
      endcase
   end

   always_comb begin
      wr_en  = 1'b0;
      wr_req = '0;
      if (ld_keep) begin
         wr_en  = 1'b1;
         wr_req = '{rd: ld_rd, data: ld_ext};
      end else if (!fifo_empty) begin
         wr_en  = 1'b1;
         wr_req = fifo_head;
      end else if (alu_keep) begin
         wr_en  = 1'b1;
         wr_req = alu_req;
      end
   end

   rv64_wb_fifo #(
      .DEPTH (ALU_FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_req (alu_req),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         wb_en   <= wr_en;
         wb_rd   <= wr_req.rd;
         wb_data <= wr_req.data;
      end
   end

`ifdef WB_FWD_EN
   assign fwd_rs1_hit  = wb_en && (wb_rd == fwd_rs1_index) && (fwd_rs1_index != 5'd0);
   assign fwd_rs2_hit  = wb_en && (wb_rd == fwd_rs2_index) && (fwd_rs2_index != 5'd0);
   assign fwd_rs1_data = wb_data;
   assign fwd_rs2_data = wb_data;
`endif

endmodule

// File: tb/tb_rv64_wb_unit.sv
// Directed bench for rv64_wb_unit: load extension, arbitration, FIFO
// ordering/backpressure, x0 drops, reset flush and optional forwarding.
module tb_rv64_wb_unit;
   import rv64_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [63:0] ld_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        alu_pending;
   logic [4:0]  fwd_rs1_index, fwd_rs2_index;
   logic        fwd_rs1_hit, fwd_rs2_hit;
   logic [63:0] fwd_rs1_data, fwd_rs2_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv64_wb_unit #(.XLEN(64), .ALU_FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .ld_valid      (ld_valid),
      .ld_ready      (ld_ready),
      .ld_rd         (ld_rd),
      .ld_funct3     (ld_funct3),
      .ld_data       (ld_data),
      .wb_en         (wb_en),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
`ifdef WB_FWD_EN
      .fwd_rs1_index (fwd_rs1_index),
      .fwd_rs2_index (fwd_rs2_index),
      .fwd_rs1_hit   (fwd_rs1_hit),
      .fwd_rs2_hit   (fwd_rs2_hit),
      .fwd_rs1_data  (fwd_rs1_data),
      .fwd_rs2_data  (fwd_rs2_data),
`endif
      .alu_pending   (alu_pending)
   );

`ifndef WB_FWD_EN
   assign fwd_rs1_hit  = 1'b0;
   assign fwd_rs2_hit  = 1'b0;
   assign fwd_rs1_data = '0;
   assign fwd_rs2_data = '0;
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_funct3 = FUNCT3_LD; ld_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [63:0] data);
      chk({tag, ".en"}, 64'(wb_en), 64'(en));
      if (en) begin
         chk({tag, ".rd"},   64'(wb_rd), 64'(rd));
         chk({tag, ".data"}, wb_data, data);
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [63:0] din;
      logic [63:0] dout;
   } ld_vec_t;

   ld_vec_t ld_vecs[9];
   logic [4:0] exp_rd[7];
   logic       exp_rdy[5];

   initial begin
      ld_vecs[0] = '{3'b000, 64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_FFF0};
      ld_vecs[1] = '{3'b100, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00F0};
      ld_vecs[2] = '{3'b000, 64'hAAAA_AAAA_AAAA_017F, 64'h0000_0000_0000_007F};
      ld_vecs[3] = '{3'b001, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001};
      ld_vecs[4] = '{3'b010, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
      ld_vecs[5] = '{3'b011, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
      ld_vecs[6] = '{3'b101, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001};
      ld_vecs[7] = '{3'b110, 64'hFFFF_FFFF_F000_0000, 64'h0000_0000_F000_0000};
      ld_vecs[8] = '{3'b111, 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D};
      exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      idle();
      fwd_rs1_index = '0;
      fwd_rs2_index = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wb_en", 64'(wb_en), 64'd0);
      chk("rst.wb_rd", 64'(wb_rd), 64'd0);
      chk("rst.wb_data", wb_data, 64'd0);
      chk("rst.alu_pending", 64'(alu_pending), 64'd0);
      chk("rst.alu_ready", 64'(alu_ready), 64'd0);
      chk("rst.ld_ready", 64'(ld_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel.alu_ready", 64'(alu_ready), 64'd1);
      step();

      // load extension, back to back
      foreach (ld_vecs[i]) begin
         ld_valid = 1'b1; ld_rd = 5'd5;
         ld_funct3 = ld_vecs[i].f3; ld_data = ld_vecs[i].din;
         step();
         chk_wb($sformatf("ld%0d", i), 1'b1, 5'd5, ld_vecs[i].dout);
      end
      idle();
      step();
      chk_wb("ld.idle", 1'b0, 5'd0, 64'd0);

      // ALU bypass
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h1234;
      #1 chk("byp.ready", 64'(alu_ready), 64'd1);
      step();
      idle();
      chk_wb("byp", 1'b1, 5'd3, 64'h1234);
      chk("byp.pending", 64'(alu_pending), 64'd0);

      // simultaneous load and ALU
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h77;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
      step();
      idle();
      chk_wb("sim.ld", 1'b1, 5'd7, 64'h77);
      chk("sim.pending1", 64'(alu_pending), 64'd1);
      step();
      chk_wb("sim.alu", 1'b1, 5'd8, 64'h88);
      chk("sim.pending0", 64'(alu_pending), 64'd0);
      step();
      chk_wb("sim.idle", 1'b0, 5'd0, 64'd0);

      // loads starve the FIFO, backpressure, in-order drain
      begin
         int idx = 0;
         for (int c = 0; c < 7; c++) begin
            ld_valid = (c < 4);
            ld_rd    = 5'(10 + c);
            ld_data  = 64'(c);
            alu_valid = (idx < 3);
            alu_rd    = 5'(idx + 1);
            alu_data  = 64'(256 + idx + 1);
            #1;
            if (c < 5) chk($sformatf("bp.ready%0d", c), 64'(alu_ready), 64'(exp_rdy[c]));
            if (alu_valid && alu_ready) idx++;
            step();
            chk_wb($sformatf("bp.wb%0d", c), 1'b1, exp_rd[c],
                   (c < 4) ? 64'(c) : 64'(256 + exp_rd[c]));
         end
         idle();
         chk("bp.accepts", 64'(idx), 64'd3);
         chk("bp.pending", 64'(alu_pending), 64'd0);
         step();
         chk_wb("bp.idle", 1'b0, 5'd0, 64'd0);
      end

      // x0 from both sources is dropped
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h55;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h66;
      #1 chk("x0.ready", 64'(alu_ready), 64'd1);
      step();
      idle();
      chk_wb("x0", 1'b0, 5'd0, 64'd0);
      chk("x0.pending", 64'(alu_pending), 64'd0);

      // an x0 load does not block the FIFO head
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h44;
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
      step();
      chk_wb("x0h.ld", 1'b1, 5'd4, 64'h44);
      idle();
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h99;
      step();
      idle();
      chk_wb("x0h.head", 1'b1, 5'd6, 64'h66);
      chk("x0h.pending", 64'(alu_pending), 64'd0);

      // reset flush with two buffered entries and a pending write
      for (int c = 0; c < 2; c++) begin
         ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 64'hC;
         alu_valid = 1'b1; alu_rd = 5'(20 + c); alu_data = 64'(20 + c);
         step();
      end
      idle();
      chk("flush.pending_pre", 64'(alu_pending), 64'd1);
      fwd_rs1_index = 5'd12;
      rst = 1'b1;
      #1;
      chk("flush.wb_en_rst", 64'(wb_en), 64'd0);
      chk("flush.pending_rst", 64'(alu_pending), 64'd0);
      chk("flush.ready_rst", 64'(alu_ready), 64'd0);
`ifdef WB_FWD_EN
      chk("flush.fwd_rst", 64'(fwd_rs1_hit), 64'd0);
`endif
      step();
      #2 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_wb($sformatf("flush.post%0d", c), 1'b0, 5'd0, 64'd0);
         chk($sformatf("flush.pending%0d", c), 64'(alu_pending), 64'd0);
`ifdef WB_FWD_EN
         chk($sformatf("flush.fwd%0d", c), 64'(fwd_rs1_hit), 64'd0);
`endif
      end

      // write to x9 visible to decode forwarding
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'hCAFE;
      fwd_rs1_index = 5'd9; fwd_rs2_index = 5'd8;
      step();
      idle();
      chk_wb("fwd.wb", 1'b1, 5'd9, 64'hCAFE);
`ifdef WB_FWD_EN
      chk("fwd.rs1_hit", 64'(fwd_rs1_hit), 64'd1);
      chk("fwd.rs1_data", fwd_rs1_data, 64'hCAFE);
      chk("fwd.rs2_hit", 64'(fwd_rs2_hit), 64'd0);
`endif
      step();
      chk_wb("fwd.idle", 1'b0, 5'd0, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv64_wb_unit.md
# rv64_wb_unit

Writeback unit feeding the 64-bit integer register file write port. It accepts completed results from the ALU pipe and the load unit over valid/ready handshakes and sign- or zero-extends load data. It arbitrates the two sources and drives one registered write per cycle (wb_en, wb_rd, wb_data) into the register file. An optional same-cycle forwarding path lets decode see the value that is about to land.

## Interface
- XLEN, 64: datapath width.
- ALU_FIFO_DEPTH, 2: ALU result buffer entries; power of two, at least 2.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when both alu_valid and alu_ready are high.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered; the load unit cannot stall.
- ld_ready  out  1  tied high.
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type.
- ld_data  in  XLEN  raw load data, right-aligned.
- wb_en  out  1  register-file write enable.
- wb_rd  out  5  register-file write index.
- wb_data  out  XLEN  register-file write data.
- alu_pending  out  1  ALU FIFO not empty.
- fwd_rs1_index, fwd_rs2_index  in  5 each  decode read indices (WB_FWD_EN only).
- fwd_rs1_hit, fwd_rs2_hit  out  1 each  forward valid (WB_FWD_EN only).
- fwd_rs1_data, fwd_rs2_data  out  XLEN each  forward data (WB_FWD_EN only).

## Operation
- Load extension by ld_funct3:
  - 000 LB sign-extends bits [7:0].
  - 001 LH sign-extends bits [15:0].
  - 010 LW sign-extends bits [31:0].
  - 011 LD passes the data through.
  - 100 LBU, 101 LHU and 110 LWU zero-extend.
  - 111 passes the raw data through.
- rd = 0 from either source:
  - The handshake completes but the result is discarded.
  - It is not pushed to the FIFO and never raises wb_en.
- Arbitration per cycle, in fixed priority:
  1. An accepted load, if present, is written.
  2. Otherwise the FIFO head is written.
  3. Otherwise an ALU result accepted this cycle bypasses the FIFO and is written. Bypass is allowed only when the FIFO is empty.
- FIFO:
  - An accepted ALU result that is not written this cycle is pushed.
  - Push and pop in the same cycle are allowed, including when the FIFO is full: pop frees the slot, and alu_ready = !full || pop_this_cycle.
  - ALU results retire strictly in acceptance order.
  - Loads may overtake buffered ALU results. Issue logic guarantees no write-after-write to the same rd between an outstanding load and a buffered ALU result; this block does not check it.
- FIFO pointers are log2(ALU_FIFO_DEPTH)+1 bits wide, using wrap bits for full/empty detection; the count never exceeds ALU_FIFO_DEPTH.

## Timing
- Reset values:
  - wb_en 0, wb_rd 0, wb_data 0.
  - FIFO empty, alu_pending 0.
  - alu_ready 0 while rst is high; alu_ready 1 from the first cycle after reset release.
- Load latency: accepted at edge N, the write is on wb_* during cycle N+1 and lands in the register file at edge N+2.
- ALU latency:
  - 1 cycle via bypass.
  - Otherwise 1 cycle plus the cycles spent waiting behind loads and earlier FIFO entries.
- wb_en is high for exactly one cycle per retired nonzero-rd result.
- Back-to-back loads starve the FIFO indefinitely. The FIFO fills after ALU_FIFO_DEPTH accepts, and alu_ready then drops in the same cycle as the last accept becomes visible.
- Reset asserted mid-operation flushes buffered ALU results and any pending output write; nothing from before reset is written after release.

## Configuration
- WB_FWD_EN defined: the fwd_* ports exist.
  - fwd_rsX_hit = wb_en && wb_rd == fwd_rsX_index && fwd_rsX_index != 0, combinational.
  - fwd_rsX_data = wb_data.
- WB_FWD_EN undefined: the fwd_* ports and logic are absent. Decode must then stall one cycle on a matching wb_rd itself.

## Structure
- The shared rv64 package holds:
  - load funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU);
  - the XLEN default;
  - a wb_req struct of rd and data.
- One sub-module, rv64_wb_fifo: the parameterized synchronous FIFO with push, pop, full, empty and simultaneous push/pop support.
- Load extension and arbitration stay in the top level.

## Test plan
- Load LB with ld_data=0x00000000000000F0 and rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=0xFFFFFFFFFFFFFFF0. The same data as LBU -> 0x00000000000000F0.
- ALU result with rd=3, data=0x1234, FIFO empty, no load -> next cycle wb_en=1, wb_rd=3, wb_data=0x1234; alu_pending stays 0.
- Simultaneous load (rd=7) and ALU result (rd=8):
  - next cycle, the rd=7 write; the cycle after, the rd=8 write;
  - alu_pending is 1 for exactly one cycle.
- Loads held valid for 4 cycles while ALU offers 3 results (rd=1,2,3):
  - alu_ready drops after 2 accepts;
  - after the loads stop, rd=1 and rd=2 retire in order, then rd=3 is accepted and written.
- rd=0 from both sources -> handshakes complete, wb_en stays 0, FIFO unchanged.
- Reset pulse with 2 FIFO entries buffered -> wb_en stays 0 after release and alu_pending=0. With WB_FWD_EN defined, fwd_rs1_hit=0 during the reset pulse and after release; and during an rd=9 write with fwd_rs1_index=9 -> fwd_rs1_hit=1 and fwd_rs1_data=wb_data.
